alu_cmd_sequencer: RTL

//  Upstream issue stage for the 8-bit ALU. Accepts register-addressed ALU commands (valid/ready)
//  and holds a small register file. Reads operands, drives ALU A/B/op, captures ALU out and

---
 rtl/alu_cmd_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_cmd_sequencer
//  Purpose  : Issue stage for an external combinational ALU. Accepts
//             register-addressed commands, reads operands from a small
//             register file, drives the ALU for one cycle, writes the result
//             back and returns a response with result and error flag.
//  Ports    : clk, rst_n                 - clock, synchronous active-low reset
//             cmd_valid/cmd_ready        - command handshake
//             cmd_op/rd/rs1/rs2/imm_en/imm - command fields
//             wr_en/wr_addr/wr_data      - external register-file write port
//             alu_a/alu_b/alu_op         - registered drive to the ALU
//             alu_out                    - combinational result from the ALU
//             rsp_valid/rsp_ready        - response handshake
//             rsp_data/rsp_rd/rsp_err    - response payload
//  Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [AW-1:0]     cmd_rd,
  input  logic [AW-1:0]     cmd_rs1,
  input  logic [AW-1:0]     cmd_rs2,
  input  logic              cmd_imm_en,
  input  logic [DATA_W-1:0] cmd_imm,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [AW-1:0]     rsp_rd,
  output logic              rsp_err
);

  localparam logic [3:0] C_OP_LSL   = 4'd2;
  localparam logic [3:0] C_OP_LSR   = 4'd4;
  localparam logic [3:0] C_OP_LAST  = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   regs_q [NREGS];
  logic [DATA_W-1:0]   alu_a_q;
  logic [DATA_W-1:0]   alu_b_q;
  logic [3:0]          alu_op_q;
  logic [AW-1:0]       rd_q;
  logic                err_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic [AW-1:0]       rsp_rd_q;
  logic                rsp_err_q;

  // Operand values to be latched at command accept
  logic                illegal_d;
  logic [DATA_W-1:0]   b_d;
  logic [3:0]          op_d;

  always_comb begin
    illegal_d = (cmd_op > C_OP_LAST);
    b_d       = cmd_imm_en ? cmd_imm : regs_q[cmd_rs2];
    // Shifts only use a 3-bit amount; upper bits of B are cleared
    if (cmd_op >= C_OP_LSL && cmd_op <= C_OP_LSR) begin
      b_d = {{(DATA_W-3){1'b0}}, b_d[2:0]};
    end
    op_d = illegal_d ? 4'd0 : cmd_op;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rd_q        <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_rd_q    <= '0;
      rsp_err_q   <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      // External write first so that a same-address writeback below overrides it
      if (wr_en) begin
        regs_q[wr_addr] <= wr_data;
      end
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            alu_a_q  <= regs_q[cmd_rs1];
            alu_b_q  <= b_d;
            alu_op_q <= op_d;
            rd_q     <= cmd_rd;
            err_q    <= illegal_d;
            state_q  <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_valid_q <= 1'b1;
          rsp_rd_q    <= rd_q;
          rsp_err_q   <= err_q;
          if (err_q) begin
            rsp_data_q <= '0;
          end else begin
            rsp_data_q   <= alu_out;
            regs_q[rd_q] <= alu_out;
          end
          state_q <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = rst_n && (state_q == S_IDLE);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_rd    = rsp_rd_q;
  assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire
